ram_bytelane_pipelined: RTL and testbench
=========================================

// Module: ram_bytelane_pipelined
// PURPOSE
//  Byte-addressable, little-endian data memory with LANES byte lanes and a registered request/response port.
//  Successor to the fixed 64-bit RAM: lane count and depth are parametrised, and the tri-state bus is replaced by
//  a valid/ready handshake. Adds a zeroing init sequence, signed loads, and an out-of-range error flag.
//  Accesses may be unaligned and may cross a word boundary; each completes in a single access cycle.
//  Sits between the CPU load/store unit and the physical lane RAMs.
// PARAMETERS
//  LANES       8   byte lanes per word; power of two, >=2; data width = 8*LANES
//  ADDR_WIDTH  12  byte-address width; memory = 2**ADDR_WIDTH bytes
//  INIT_ZERO   1   1: clear all words after reset before accepting requests; 0: skip init
//  (derived) LB = clog2(LANES); SIZE_W = clog2(LB+1); access bytes N = 2**req_size
// PORTS
//  clock        in   1            rising-edge clock
//  reset        in   1            asynchronous, active-high reset
//  req_valid    in   1            request present
//  req_ready    out  1            request accepted when req_valid & req_ready
//  req_write    in   1            1 = store, 0 = load
//  req_signed   in   1            load: sign-extend from bit 8N-1 (ignored for stores)
//  req_size     in   SIZE_W       log2 of access bytes (0=8b,1=16b,2=32b,3=64b for LANES=8)
//  req_address  in   ADDR_WIDTH   byte address of the least-significant byte
//  req_wdata    in   8*LANES      store data, right-justified; bits above 8N ignored
//  rsp_valid    out  1            response present
//  rsp_ready    in   1            response consumed when rsp_valid & rsp_ready
//  rsp_rdata    out  8*LANES      load data, right-justified and extended; 0 for stores and errors
//  rsp_error    out  1            request rejected (no memory change)
//  init_done    out  1            init sequence complete
// BEHAVIOUR
//  - Reset (async): rsp_valid=0, rsp_rdata=0, rsp_error=0, req_ready=0, init_done=0; state=INIT if INIT_ZERO, else READY.
//    Memory contents are not reset directly.
//  - States INIT -> READY. INIT: counter 0..2**(ADDR_WIDTH-LB)-1; writes 0 to every lane of that word, one word/cycle.
//    After the last word: READY, init_done=1 (sticky until reset). Reset during INIT restarts the counter at 0.
//  - req_ready = (state==READY) & (!rsp_valid | rsp_ready). Exactly one response per accepted request, including stores.
//  - Lane map: off=addr[LB-1:0], word=addr[ADDR_WIDTH-1:LB]. Access byte k (0..N-1) uses:
//    lane (off+k) mod LANES at word index word + ((off+k)>=LANES).
//    Lanes not covered by the access are not written.
//  - Error if req_size > LB, or address + N - 1 > 2**ADDR_WIDTH - 1 (no wrap-around).
//    On error: no write; response has rsp_error=1 and rsp_rdata=0.
//  - Store: lane RAMs written at the accept edge. Load: lane RAMs read synchronously at the accept edge into lane registers.
//    Offset, size, signed and error are captured alongside.
//  - Latency: rsp_valid=1 the cycle after acceptance. rsp_rdata is formed by rotating the lane registers by the captured
//    offset, then zero- or sign-extending from bit 8N-1 (combinational from registers).
//  - Stall: while rsp_valid & !rsp_ready, rsp_rdata and rsp_error are held stable and no request is accepted.
//  - rsp_valid falls after the handshake unless a new request is accepted in the same cycle.
//    Throughput is 1 request/cycle while rsp_ready=1.
//  - Store then load to an overlapping address in the next cycle returns the new data (no read-during-write hazard,
//    since only one access is made per cycle).
//  - Reset mid-transaction: a pending response is dropped; a store already accepted stays committed (then zeroed
//    by INIT if INIT_ZERO).
// STRUCTURE
//  - Package ram_pkg: size encodings SIZE_B/SIZE_H/SIZE_W/SIZE_D, state enum {ST_INIT, ST_READY}, lane-index helper function.
//  - Sub-module ram_lane: 8-bit-wide, 2**(ADDR_WIDTH-LB)-deep synchronous RAM (we, addr, din, dout), storage array named mem.
//    Instantiated LANES times via generate as lane[i]; the bench reads lane[i].mem directly.
// TESTING  (LANES=8, ADDR_WIDTH=12, INIT_ZERO=1)
//  1 Reset, then idle -> req_ready=0 for 512 cycles, then init_done=1; 64b load @8 -> rdata=0, error=0.
//  2 Store 64'h0706050403020100 @8 (size 3); 0x0F @23 (size 0); 0x0E0D @21 (size 1); 0x0C0B0A09 @17 (size 2);
//    0x08 @16 (size 0) -> 64b load @16 = 64'h0F0E0D0C0B0A0908.
//  3 After test 2: 32b load @14 (crosses word) -> 32'h09080706; 16b load @15 -> 16'h0807; 64b load @12 -> 64'h0B0A090807060504.
//  4 Store 0x80 @30 (size 0); signed 8b load @30 -> 64'hFFFFFFFFFFFFFF80; unsigned -> 64'h80.
//    Signed 16b load @21 -> 64'h0E0D.
//  5 64b load @4093 and 16b store @4095 -> rsp_error=1, rdata=0; byte 4095 unchanged.
//    Next legal request proceeds normally.
//  6 Hold rsp_ready=0 for 3 cycles with a load pending -> rsp_valid=1, rdata stable, req_ready=0. Release with 4 queued loads
//    -> one response/cycle, in order. Then assert reset while rsp_valid=1 -> rsp_valid=0 immediately; after re-init,
//    64b load @8 = 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared encodings and helpers for the byte-lane data memory.
package ram_pkg;

    localparam int SIZE_B = 0;
    localparam int SIZE_H = 1;
    localparam int SIZE_W = 2;
    localparam int SIZE_D = 3;

    typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

    // Position of a physical lane inside an access that starts at lane offset off.
    function automatic int lane_rel(input int lane, input int off, input int lanes);
        return (lane - off) & (lanes - 1);
    endfunction

endpackage

// File: rtl/ram_lane.sv
// One 8-bit lane of the data memory: synchronous write, registered read.
module ram_lane #(
    parameter int DEPTH_W = 9
) (
    input  logic               clock,
    input  logic               we,
    input  logic               re,
    input  logic [DEPTH_W-1:0] addr,
    input  logic [7:0]         din,
    output logic [7:0]         dout
);

    logic [7:0] mem [2**DEPTH_W];

    // Write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // Read port; dout holds its value until the next read so a stalled response stays stable.
    always_ff @(posedge clock) begin
        if (re) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_bytelane_pipelined.sv
// Byte-addressable little-endian memory with LANES byte lanes, unaligned access,
// zeroing init sequence and a valid/ready request/response port.
module ram_bytelane_pipelined #(
    parameter int LANES      = 8,
    parameter int ADDR_WIDTH = 12,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic                              req_signed,
    input  logic [$clog2($clog2(LANES)+1)-1:0] req_size,
    input  logic [ADDR_WIDTH-1:0]             req_address,
    input  logic [8*LANES-1:0]                req_wdata,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [8*LANES-1:0]                rsp_rdata,
    output logic                              rsp_error,
    output logic                              init_done
);
    import ram_pkg::*;

    localparam int LB         = $clog2(LANES);
    localparam int LB1        = LB + 1;
    localparam int SIZE_WIDTH = $clog2(LB + 1);
    localparam int DEPTH_W    = ADDR_WIDTH - LB;
    localparam int AW1        = ADDR_WIDTH + 1;
    localparam logic [DEPTH_W-1:0] LAST_WORD = '1;

    state_t                  state_r;
    logic [DEPTH_W-1:0]      init_cnt_r;
    logic                    init_done_r;
    logic                    rsp_valid_r;
    logic                    rsp_error_r;
    logic                    rsp_write_r;
    logic                    rsp_signed_r;
    logic [LB-1:0]           rsp_off_r;
    logic [SIZE_WIDTH-1:0]   rsp_size_r;

    logic                    req_ready_s;
    logic                    accept_s;
    logic                    req_error_s;
    logic [AW1-1:0]          span_s;
    logic [AW1-1:0]          last_byte_s;
    logic [LB1-1:0]          nbytes_s;
    logic [LB-1:0]           req_off_s;
    logic [DEPTH_W-1:0]      req_word_s;
    logic [7:0]              lane_dout_s [LANES];

    assign req_off_s   = req_address[LB-1:0];
    assign req_word_s  = req_address[ADDR_WIDTH-1:LB];
    assign req_ready_s = (state_r == ST_READY) && (!rsp_valid_r || rsp_ready);
    assign accept_s    = req_valid && req_ready_s;

    // Range check: oversize access or one whose last byte runs past the top of memory.
    always_comb begin
        nbytes_s = LB1'(1) << req_size;
        if (req_size > SIZE_WIDTH'(LB)) begin
            span_s = '0;
        end else begin
            span_s = (AW1'(1) << req_size) - AW1'(1);
        end
        last_byte_s = {1'b0, req_address} + span_s;
        req_error_s = (req_size > SIZE_WIDTH'(LB)) || last_byte_s[ADDR_WIDTH];
    end

    for (genvar i = 0; i < LANES; i++) begin : lane
        logic [LB-1:0]      rel_s;
        logic               covered_s;
        logic               we_s;
        logic               re_s;
        logic [DEPTH_W-1:0] addr_s;
        logic [7:0]         din_s;

        // Lanes below the start offset hold the bytes that wrapped into the next word.
        always_comb begin
            rel_s     = LB'(lane_rel(i, int'(req_off_s), LANES));
            covered_s = {1'b0, rel_s} < nbytes_s;
            re_s      = accept_s && !req_write;
            if (state_r == ST_INIT) begin
                we_s   = 1'b1;
                addr_s = init_cnt_r;
                din_s  = 8'h00;
            end else begin
                we_s   = accept_s && req_write && !req_error_s && covered_s;
                addr_s = req_word_s + DEPTH_W'(LB'(i) < req_off_s);
                din_s  = req_wdata[{rel_s, 3'b000} +: 8];
            end
        end

        ram_lane #(.DEPTH_W(DEPTH_W)) ram (
            .clock (clock),
            .we    (we_s),
            .re    (re_s),
            .addr  (addr_s),
            .din   (din_s),
            .dout  (lane_dout_s[i])
        );
    end

    // Init sequencing and response capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= INIT_ZERO ? ST_INIT : ST_READY;
            init_cnt_r   <= '0;
            init_done_r  <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_error_r  <= 1'b0;
            rsp_write_r  <= 1'b0;
            rsp_signed_r <= 1'b0;
            rsp_off_r    <= '0;
            rsp_size_r   <= '0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_cnt_r <= init_cnt_r + DEPTH_W'(1);
                    if (init_cnt_r == LAST_WORD) begin
                        state_r     <= ST_READY;
                        init_done_r <= 1'b1;
                    end
                end
                ST_READY: begin
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
            if (accept_s) begin
                rsp_valid_r  <= 1'b1;
                rsp_error_r  <= req_error_s;
                rsp_write_r  <= req_write;
                rsp_signed_r <= req_signed;
                rsp_off_r    <= req_off_s;
                rsp_size_r   <= req_size;
            end else if (rsp_ready) begin
                rsp_valid_r <= 1'b0;
                rsp_error_r <= 1'b0;
            end
        end
    end

    logic [8*LANES-1:0] rot_s;
    logic [8*LANES-1:0] rdata_s;
    logic [LB1-1:0]     rsp_nbytes_s;
    logic [7:0]         msb_byte_s;
    logic               sign_s;

    // Rotate lanes back into access order, then zero- or sign-extend above the access width.
    always_comb begin
        rsp_nbytes_s = LB1'(1) << rsp_size_r;
        msb_byte_s   = 8'h00;
        rot_s        = '0;
        rdata_s      = '0;
        for (int k = 0; k < LANES; k++) begin
            rot_s[8*k +: 8] = lane_dout_s[rsp_off_r + LB'(k)];
            if (LB1'(k) == rsp_nbytes_s - LB1'(1)) begin
                msb_byte_s = rot_s[8*k +: 8];
            end else begin
                msb_byte_s = msb_byte_s;
            end
        end
        sign_s = rsp_signed_r && msb_byte_s[7];
        for (int k = 0; k < LANES; k++) begin
            if (LB1'(k) < rsp_nbytes_s) begin
                rdata_s[8*k +: 8] = rot_s[8*k +: 8];
            end else begin
                rdata_s[8*k +: 8] = {8{sign_s}};
            end
        end
        if (!rsp_valid_r || rsp_write_r || rsp_error_r) begin
            rdata_s = '0;
        end else begin
            rdata_s = rdata_s;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_error = rsp_error_r;
    assign rsp_rdata = rdata_s;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_ram_bytelane_pipelined.sv
// Directed, table-driven bench for ram_bytelane_pipelined (LANES=8, ADDR_WIDTH=12).
module tb_ram_bytelane_pipelined;
    import ram_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [11:0] req_address = 12'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic        init_done;

    ram_bytelane_pipelined #(.LANES(8), .ADDR_WIDTH(12), .INIT_ZERO(1'b1)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_signed  (req_signed),
        .req_size    (req_size),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .init_done   (init_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic        sg;
        logic [1:0]  size;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic sg, input int size, input int addr,
                       input logic [63:0] wdata, input logic [63:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wr = wr; v.sg = sg; v.size = 2'(size); v.addr = 12'(addr);
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic wr, input logic sg, input logic [1:0] size,
                         input logic [11:0] addr, input logic [63:0] wdata);
        req_valid = 1'b1; req_write = wr; req_signed = sg;
        req_size = size; req_address = addr; req_wdata = wdata;
    endtask

    // Issue one request with rsp_ready high; entered and left 1 time unit after a rising edge.
    task automatic do_req(input string name, input logic wr, input logic sg, input logic [1:0] size,
                          input logic [11:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rdata, output logic err);
        int   waited = 0;
        logic was_ready;
        drive(wr, sg, size, addr, wdata);
        rsp_ready = 1'b1;
        do begin
            #1;
            was_ready = req_ready;
            @(posedge clock);
            #1;
            waited++;
        end while (!was_ready && waited < 50);
        req_valid = 1'b0;
        check({name, " accepted"}, 64'(was_ready), 64'd1);
        check({name, " rsp_valid"}, 64'(rsp_valid), 64'd1);
        rdata = rsp_rdata;
        err   = rsp_error;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_init(input string name, output int cycles);
        cycles = 0;
        do begin
            @(posedge clock);
            #1;
            cycles++;
        end while (!req_ready && cycles < 2000);
        check({name, " init_done"}, 64'(init_done), 64'd1);
    endtask

    logic [63:0] rd;
    logic        er;
    int          cyc;
    logic [63:0] stall_exp;
    logic [11:0] q_addr [4];
    logic [1:0]  q_size [4];
    logic [63:0] q_exp  [4];

    initial begin
        add(1'b0, 1'b0, SIZE_D,    8, 64'h0, 64'h0, 1'b0);
        add(1'b1, 1'b0, SIZE_D,    8, 64'h0706050403020100, 64'h0, 1'b0);
        add(1'b1, 1'b0, SIZE_B,   23, 64'hFFFF_FFFF_FFFF_FF0F, 64'h0, 1'b0);
        add(1'b1, 1'b0, SIZE_H,   21, 64'h0E0D, 64'h0, 1'b0);
        add(1'b1, 1'b0, SIZE_W,   17, 64'h0C0B0A09, 64'h0, 1'b0);
        add(1'b1, 1'b0, SIZE_B,   16, 64'h08, 64'h0, 1'b0);
        add(1'b0, 1'b0, SIZE_D,   16, 64'h0, 64'h0F0E0D0C0B0A0908, 1'b0);
        add(1'b0, 1'b0, SIZE_W,   14, 64'h0, 64'h09080706, 1'b0);
        add(1'b0, 1'b0, SIZE_H,   15, 64'h0, 64'h0807, 1'b0);
        add(1'b0, 1'b0, SIZE_D,   12, 64'h0, 64'h0B0A090807060504, 1'b0);
        add(1'b0, 1'b0, SIZE_D,   19, 64'h0, 64'h0000000F0E0D0C0B, 1'b0);
        add(1'b1, 1'b0, SIZE_B,   30, 64'h80, 64'h0, 1'b0);
        add(1'b0, 1'b1, SIZE_B,   30, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0);
        add(1'b0, 1'b0, SIZE_B,   30, 64'h0, 64'h80, 1'b0);
        add(1'b0, 1'b1, SIZE_H,   21, 64'h0, 64'h0E0D, 1'b0);
        add(1'b1, 1'b0, SIZE_H,   40, 64'h8001, 64'h0, 1'b0);
        add(1'b0, 1'b1, SIZE_H,   40, 64'h0, 64'hFFFFFFFFFFFF8001, 1'b0);
        add(1'b1, 1'b0, SIZE_B,   50, 64'h1234, 64'h0, 1'b0);
        add(1'b0, 1'b0, SIZE_H,   50, 64'h0, 64'h0034, 1'b0);
        add(1'b0, 1'b0, SIZE_D, 4093, 64'h0, 64'h0, 1'b1);
        add(1'b1, 1'b0, SIZE_H, 4095, 64'hABCD, 64'h0, 1'b1);
        add(1'b0, 1'b0, SIZE_B, 4095, 64'h0, 64'h0, 1'b0);
        add(1'b0, 1'b0, SIZE_H, 4094, 64'h0, 64'h0, 1'b0);

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_rdata", rsp_rdata, 64'd0);
        check("reset rsp_error", 64'(rsp_error), 64'd0);
        check("reset req_ready", 64'(req_ready), 64'd0);
        check("reset init_done", 64'(init_done), 64'd0);
        reset = 1'b0;

        // Init takes one cycle per word: 4096/8 = 512 cycles of req_ready low.
        wait_init("init", cyc);
        check("init cycles", 64'(cyc), 64'd512);

        foreach (vecs[i]) begin
            do_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sg, vecs[i].size,
                   vecs[i].addr, vecs[i].wdata, rd, er);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d error", i), 64'(er), 64'(vecs[i].exp_err));
        end
        check("byte 4095 untouched", 64'(dut.lane[7].ram.mem[511]), 64'h0);

        // Stall: load pending with rsp_ready low, another request waiting.
        stall_exp = 64'h0F0E0D0C0B0A0908;
        drive(1'b0, 1'b0, 2'(SIZE_D), 12'd16, 64'h0);
        rsp_ready = 1'b0;
        #1;
        check("stall first ready", 64'(req_ready), 64'd1);
        @(posedge clock);
        #1;
        q_addr[0] = 12'd8;  q_size[0] = 2'(SIZE_D); q_exp[0] = 64'h0706050403020100;
        q_addr[1] = 12'd12; q_size[1] = 2'(SIZE_D); q_exp[1] = 64'h0B0A090807060504;
        q_addr[2] = 12'd14; q_size[2] = 2'(SIZE_W); q_exp[2] = 64'h09080706;
        q_addr[3] = 12'd15; q_size[3] = 2'(SIZE_H); q_exp[3] = 64'h0807;
        drive(1'b0, 1'b0, q_size[0], q_addr[0], 64'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d rsp_valid", c), 64'(rsp_valid), 64'd1);
            check($sformatf("stall%0d rdata", c), rsp_rdata, stall_exp);
            check($sformatf("stall%0d req_ready", c), 64'(req_ready), 64'd0);
            @(posedge clock);
            #1;
        end
        check("stall held rdata", rsp_rdata, stall_exp);

        // Release: one response per cycle, in order.
        rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 1'b0, q_size[j], q_addr[j], 64'h0);
            #1;
            check($sformatf("burst%0d req_ready", j), 64'(req_ready), 64'd1);
            @(posedge clock);
            #1;
            check($sformatf("burst%0d rsp_valid", j), 64'(rsp_valid), 64'd1);
            check($sformatf("burst%0d rdata", j), rsp_rdata, q_exp[j]);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;

        // Reset with a response pending.
        #1;
        check("pre-reset rsp_valid", 64'(rsp_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("async reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("async reset req_ready", 64'(req_ready), 64'd0);
        check("async reset init_done", 64'(init_done), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        wait_init("reinit", cyc);
        check("reinit cycles", 64'(cyc), 64'd512);
        do_req("post-reset load", 1'b0, 1'b0, 2'(SIZE_D), 12'd8, 64'h0, rd, er);
        check("post-reset rdata", rd, 64'h0);
        check("post-reset error", 64'(er), 64'd0);
        check("post-reset mem byte16", 64'(dut.lane[0].ram.mem[2]), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
